seq_checker_q5: RTL and testbench

Receive-side checker for the 8-code shift/fold counter sequence 05, 0A, 14, 28, 50, A0, 41, 82, then back to 05. It samples an 8-bit stream and acquires lock after a run of consecutive correct codes. Once locked it tracks the phase of the stream, flags corrupted samples, and drops lock after repeated misses. It sits on the consumer side of the sequence-generator output, gated by a sample-valid strobe.

---
 rtl/seq_checker_q5.sv | 151 +++++++++++++++
 tb/tb_seq_checker_q5.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_checker_q5.sv
// Receive-side lock checker for the 8-code shift/fold sequence 05,0A,14,28,50,A0,41,82.
// Acquires lock after LOCK_COUNT in-order codes and drops it after MISS_LIMIT straight misses.
module seq_checker_q5 #(
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned MISS_LIMIT = 2
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       seq_valid,
  input  logic [7:0] seq_in,
  input  logic       clr_err,
  output logic       locked,
  output logic [2:0] phase,
  output logic       error,
  output logic       wrap,
  output logic [7:0] err_count
);

  localparam logic [2:0] LockCnt = 3'(LOCK_COUNT);
  localparam logic [2:0] MissLim = 3'(MISS_LIMIT);

  typedef enum logic [1:0] {StHunt, StConfirm, StLocked} state_e;

  state_e     state_q, state_d;
  logic [2:0] exp_q, exp_d;
  logic [2:0] match_q, match_d;
  logic [2:0] miss_q, miss_d;
  logic [2:0] phase_q, phase_d;
  logic       error_q, error_d;
  logic       wrap_q, wrap_d;
  logic [7:0] err_q, err_d;

  logic       hit;
  logic [2:0] hit_idx;
  logic       exp_hit;

  function automatic logic [7:0] code_of(input logic [2:0] idx);
    logic [7:0] code;
    case (idx)
      3'd0:    code = 8'h05;
      3'd1:    code = 8'h0A;
      3'd2:    code = 8'h14;
      3'd3:    code = 8'h28;
      3'd4:    code = 8'h50;
      3'd5:    code = 8'hA0;
      3'd6:    code = 8'h41;
      default: code = 8'h82;
    endcase
    return code;
  endfunction

  // Table membership search; codes are distinct so at most one index hits.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (seq_in == code_of(3'(i))) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

  assign exp_hit = (seq_in == code_of(exp_q));

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    match_d = match_q;
    miss_d  = miss_q;
    phase_d = phase_q;
    error_d = 1'b0;
    wrap_d  = 1'b0;
    err_d   = err_q;

    if (seq_valid) begin
      unique case (state_q)
        StHunt, StConfirm: begin
          if (state_q == StConfirm && exp_hit) begin
            phase_d = exp_q;
            exp_d   = exp_q + 3'd1;
            match_d = match_q + 3'd1;
            if (match_q + 3'd1 == LockCnt) begin
              state_d = StLocked;
              miss_d  = 3'd0;
            end
          end else if (hit) begin
            // A table member (re)starts a run from wherever it sits in the table.
            phase_d = hit_idx;
            exp_d   = hit_idx + 3'd1;
            match_d = 3'd1;
            miss_d  = 3'd0;
            state_d = (LockCnt == 3'd1) ? StLocked : StConfirm;
          end else begin
            state_d = StHunt;
          end
        end
        StLocked: begin
          exp_d = exp_q + 3'd1;
          if (exp_hit) begin
            phase_d = exp_q;
            miss_d  = 3'd0;
            wrap_d  = (exp_q == 3'd7);
          end else begin
            // Flywheel: the missed slot is still consumed so phase tracking survives.
            error_d = 1'b1;
            err_d   = (err_q != 8'hFF) ? err_q + 8'd1 : err_q;
            miss_d  = miss_q + 3'd1;
            if (miss_q + 3'd1 == MissLim) begin
              state_d = StHunt;
              miss_d  = 3'd0;
              match_d = 3'd0;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end

    if (clr_err) err_d = 8'd0;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= StHunt;
      exp_q   <= 3'd0;
      match_q <= 3'd0;
      miss_q  <= 3'd0;
      phase_q <= 3'd0;
      error_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      phase_q <= phase_d;
      error_q <= error_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign locked    = (state_q == StLocked);
  assign phase     = phase_q;
  assign error     = error_q;
  assign wrap      = wrap_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_seq_checker_q5.sv
// Scoreboard bench for seq_checker_q5: stimulus pushes model predictions, a monitor checks
// them one cycle per entry, just after each rising edge.
module tb_seq_checker_q5;

  localparam int LockCount = 3;
  localparam int MissLimit = 2;

  logic       clk = 1'b0;
  logic       clear_n = 1'b1;
  logic       seq_valid = 1'b0;
  logic [7:0] seq_in = 8'h00;
  logic       clr_err = 1'b0;
  logic       locked;
  logic [2:0] phase;
  logic       error;
  logic       wrap;
  logic [7:0] err_count;

  seq_checker_q5 #(
    .LOCK_COUNT(LockCount),
    .MISS_LIMIT(MissLimit)
  ) dut (
    .clk      (clk),
    .clear_n  (clear_n),
    .seq_valid(seq_valid),
    .seq_in   (seq_in),
    .clr_err  (clr_err),
    .locked   (locked),
    .phase    (phase),
    .error    (error),
    .wrap     (wrap),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Expected outputs after an edge: {locked, phase[2:0], error, wrap, err_count[7:0]}.
  logic [13:0] exp_q[$];

  // Reference model: run length while unlocked, next expected table slot, misses in lock.
  logic [7:0] tbl[8] = '{8'h05, 8'h0A, 8'h14, 8'h28, 8'h50, 8'hA0, 8'h41, 8'h82};
  int m_run = 0;
  bit m_locked = 0;
  int m_nxt = 0;
  int m_miss = 0;
  int m_phase = 0;
  int m_ec = 0;
  bit m_err, m_wrap;
  int lock_misses = 0;

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s at %0t: got locked=%0b phase=%0d error=%0b wrap=%0b err_count=%02h, want locked=%0b phase=%0d error=%0b wrap=%0b err_count=%02h",
               name, $time, got[13], got[12:10], got[9], got[8], got[7:0],
               want[13], want[12:10], want[9], want[8], want[7:0]);
    end
  endtask

  function automatic int idx_of(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (tbl[i] == v) return i;
    return -1;
  endfunction

  task automatic model_sample(input logic [7:0] v);
    int k;
    k = idx_of(v);
    if (m_locked) begin
      if (v == tbl[m_nxt]) begin
        m_phase = m_nxt;
        m_wrap  = (m_nxt == 7);
        m_miss  = 0;
      end else begin
        m_err = 1;
        lock_misses++;
        if (m_ec < 255) m_ec++;
        m_miss++;
        if (m_miss == MissLimit) begin
          m_locked = 0;
          m_run    = 0;
          m_miss   = 0;
        end
      end
      m_nxt = (m_nxt + 1) % 8;
    end else begin
      if (m_run > 0 && v == tbl[m_nxt]) begin
        m_run++;
        m_phase = m_nxt;
        m_nxt   = (m_nxt + 1) % 8;
      end else if (k >= 0) begin
        m_run   = 1;
        m_phase = k;
        m_nxt   = (k + 1) % 8;
      end else begin
        m_run = 0;
      end
      if (m_run == LockCount) begin
        m_locked = 1;
        m_miss   = 0;
      end
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit c);
    seq_valid = v;
    seq_in    = d;
    clr_err   = c;
    m_err     = 0;
    m_wrap    = 0;
    if (v) model_sample(d);
    if (c) m_ec = 0;
    exp_q.push_back({m_locked, 3'(m_phase), m_err, m_wrap, 8'(m_ec)});
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'b0);
  endtask

  // Assert reset mid-cycle; outputs must clear before the next edge.
  task automatic do_reset();
    #2 clear_n = 1'b0;
    #1 check("async_reset", {locked, phase, error, wrap, err_count}, 14'd0);
    m_run = 0; m_locked = 0; m_nxt = 0; m_miss = 0; m_phase = 0; m_ec = 0;
    seq_valid = 1'b0;
    clr_err   = 1'b0;
    exp_q.push_back(14'd0);
    @(negedge clk);
    clear_n = 1'b1;
  endtask

  // Monitor: one prediction per cycle, sampled 1 time unit after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("scoreboard", {locked, phase, error, wrap, err_count},
                                  exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    @(negedge clk);
    do_reset();

    // Acquire.
    send(8'h05); send(8'h0A); send(8'h14); send(8'h28);

    // Mid-sequence acquire with gaps, then wrap.
    do_reset();
    send(8'h41); idle(2); send(8'h82); idle(2); send(8'h05);
    send(8'h0A); send(8'h14); send(8'h28); send(8'h50); send(8'hA0); send(8'h41); send(8'h82);
    idle(2);

    // Single corruption, then loss of lock and reacquire.
    do_reset();
    send(8'h05); send(8'h0A); send(8'h14); send(8'h28);
    send(8'h28); send(8'hA0);
    send(8'h41); send(8'hFF); send(8'hFF);
    send(8'h14); send(8'h28); send(8'h50);

    // CONFIRM restart.
    do_reset();
    send(8'h05); send(8'h0A); send(8'h50); send(8'hA0); send(8'h41);

    // Saturation: drive lock-mode mismatches, relocking as needed.
    lock_misses = 0;
    while (lock_misses < 300) begin
      if (m_locked) send(8'hFF);
      else if (m_run > 0) send(tbl[m_nxt]);
      else send(8'h05);
    end
    idle(1);
    while (!m_locked) send(m_run > 0 ? tbl[m_nxt] : 8'h05);
    step(1'b1, 8'hFF, 1'b1);

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) d = (m_run > 0 || m_locked) ? tbl[m_nxt] : tbl[$urandom_range(0, 7)];
      else if (r == 7) d = 8'($urandom);
      else d = tbl[$urandom_range(0, 7)];
      if ($urandom_range(0, 99) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, d, $urandom_range(0, 49) == 0);
    end

    // Reset while locked.
    while (!m_locked) send(m_run > 0 ? tbl[m_nxt] : 8'h05);
    do_reset();
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending predictions, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
